// File: rtl/cnn_tick_scheduler.sv
// -----------------------------------------------------------------------------
// cnn_tick_scheduler
//
// Purpose:
//   Hands out one-cycle "tick" enables to the CNN pipeline stages. Time is
//   divided into periods of div clock cycles. At the start of each period, one
//   requesting stage may receive a tick. Stages are served round-robin from a
//   rotating pointer, so a stage that keeps requesting cannot starve the
//   others. A stop request lets the current period run out (DRAIN) before the
//   scheduler returns to IDLE.
//
// Ports:
//   clock_in  in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   cfg_we    in   1      divisor write strobe (accepted only in IDLE)
//   cfg_div   in   CNT_W  divisor value; values below 2 are rejected
//   start     in   1      start-scheduling pulse (IDLE only)
//   stop      in   1      stop-scheduling pulse (RUN only, beats start)
//   req       in   N_REQ  per-stage tick request, sampled at period start
//   tick_en   out  N_REQ  one-hot, one-cycle enable to the granted stage
//   grant_id  out  2      index of the most recent grant
//   busy      out  1      high whenever the scheduler is not IDLE
//   cfg_err   out  1      one-cycle pulse after a rejected divisor write
// -----------------------------------------------------------------------------
module cnn_tick_scheduler #(
   parameter int N_REQ       = 4,
   parameter int CNT_W       = 28,
   parameter int DIV_DEFAULT = 6
) (
   input  logic             clock_in,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             start,
   input  logic             stop,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] tick_en,
   output logic [1:0]       grant_id,
   output logic             busy,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] div_q,      div_d;
   logic [1:0]       ptr_q,      ptr_d;
   logic [N_REQ-1:0] tick_en_q,  tick_en_d;
   logic [1:0]       grant_id_q, grant_id_d;
   logic             cfg_err_q,  cfg_err_d;

   // ---------------------------------------------------------------------------
   // Round-robin search. The request vector is rotated so that bit 0 of
   // req_rot is the stage the pointer names; the lowest set bit of req_rot is
   // then the first requester at or after the pointer, with wrap-around.
   // ---------------------------------------------------------------------------
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [1:0]         grant_off;
   logic [1:0]         grant_idx;
   logic               req_found;

   assign req_dbl = {req, req};

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign req_rot[gi] = req_dbl[{1'b0, ptr_q} + 3'(gi)];
      end
   endgenerate

   always_comb begin
      grant_off = '0;
      // Walk from the top down so the lowest set offset is the one that sticks.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            grant_off = 2'(k);
         end
      end
   end

   assign req_found = |req_rot;
   assign grant_idx = ptr_q + grant_off;   // 2-bit add wraps modulo 4

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   logic cnt_last;
   assign cnt_last = (cnt_q == div_q - CNT_W'(1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      tick_en_d  = '0;
      cfg_err_d  = 1'b0;

      // A divisor of 0 or 1 would give a degenerate period, and changing the
      // divisor while counting would tear the current period, so both are
      // refused and flagged.
      if (cfg_we) begin
         if ((state_q == ST_IDLE) && (cfg_div >= CNT_W'(2))) begin
            div_d = cfg_div;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end

         ST_RUN: begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
            // Only the request value at the first cycle of a period counts; an
            // empty slot leaves the pointer where it was.
            if ((cnt_q == '0) && req_found) begin
               tick_en_d  = N_REQ'(1) << grant_idx;
               grant_id_d = grant_idx;
               ptr_d      = grant_idx + 2'd1;
            end
            // The grant above still goes out on the edge that sees stop.
            if (stop) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
            if (cnt_last) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock_in) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= CNT_W'(DIV_DEFAULT);
         ptr_q      <= '0;
         tick_en_q  <= '0;
         grant_id_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         ptr_q      <= ptr_d;
         tick_en_q  <= tick_en_d;
         grant_id_q <= grant_id_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign tick_en  = tick_en_q;
   assign grant_id = grant_id_q;
   assign cfg_err  = cfg_err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cnn_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cnn_tick_scheduler
//
// Directed stimulus for cnn_tick_scheduler. A cycle model of the scheduling
// rules (period phase, round-robin pointer, divisor) predicts every output
// each cycle; directed checks with hand-computed gaps and grant values pin
// the model to the required behaviour.
// -----------------------------------------------------------------------------
module tb_cnn_tick_scheduler;

   localparam int CNT_W = 28;

   logic             clock_in = 1'b0;
   logic             rst      = 1'b1;
   logic             cfg_we   = 1'b0;
   logic [CNT_W-1:0] cfg_div  = '0;
   logic             start    = 1'b0;
   logic             stop     = 1'b0;
   logic [3:0]       req      = '0;
   logic [3:0]       tick_en;
   logic [1:0]       grant_id;
   logic             busy;
   logic             cfg_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   cnn_tick_scheduler #(
      .N_REQ      (4),
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(6)
   ) dut (
      .clock_in(clock_in),
      .rst     (rst),
      .cfg_we  (cfg_we),
      .cfg_div (cfg_div),
      .start   (start),
      .stop    (stop),
      .req     (req),
      .tick_en (tick_en),
      .grant_id(grant_id),
      .busy    (busy),
      .cfg_err (cfg_err)
   );

   always #5 clock_in = ~clock_in;

   // ---------------------------------------------------------------------------
   // Behavioural model: mode 0 = idle, 1 = running, 2 = draining.
   // phase is the position inside the current period, 0 .. dv-1.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [1:0] mode;
      int         phase;
      int         dv;
      logic [1:0] ptr;
      logic [3:0] tick;
      logic [1:0] gid;
      logic       err;
   } mstate_t;

   mstate_t m;
   bit      model_valid = 1'b0;

   function automatic mstate_t model_step(input mstate_t cur, input logic rst_v,
                                          input logic cfg_we_v,
                                          input logic [CNT_W-1:0] cfg_div_v,
                                          input logic start_v, input logic stop_v,
                                          input logic [3:0] req_v);
      mstate_t n;
      int      g;
      if (rst_v) begin
         n    = '0;
         n.dv = 6;
         return n;
      end
      n      = cur;
      n.tick = '0;
      n.err  = 1'b0;
      if (cfg_we_v) begin
         if (cur.mode == 2'd0 && cfg_div_v >= 2) n.dv = int'(cfg_div_v);
         else                                    n.err = 1'b1;
      end
      case (cur.mode)
         2'd0: begin
            if (start_v && !stop_v) begin
               n.mode  = 2'd1;
               n.phase = 0;
            end
         end
         2'd1: begin
            if (cur.phase == 0 && req_v != 4'd0) begin
               g = -1;
               for (int k = 0; k < 4; k++) begin
                  if (g < 0 && req_v[(int'(cur.ptr) + k) % 4]) g = (int'(cur.ptr) + k) % 4;
               end
               n.tick = 4'(1 << g);
               n.gid  = 2'(g);
               n.ptr  = 2'((g + 1) % 4);
            end
            n.phase = (cur.phase + 1) % cur.dv;
            if (stop_v) n.mode = 2'd2;
         end
         2'd2: begin
            n.phase = (cur.phase + 1) % cur.dv;
            if (n.phase == 0) n.mode = 2'd0;
         end
         default: n.mode = 2'd0;
      endcase
      return n;
   endfunction

   always @(posedge clock_in) begin
      m   <= model_step(m, rst, cfg_we, cfg_div, start, stop, req);
      cyc <= cyc + 1;
      if (rst) model_valid <= 1'b1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock_in) begin
      if (model_valid) begin
         checks++;
         if (tick_en !== m.tick) begin
            errors++;
            $display("FAIL cmp_tick_en cycle %0d: got %b want %b", cyc, tick_en, m.tick);
         end
         checks++;
         if (grant_id !== m.gid) begin
            errors++;
            $display("FAIL cmp_grant_id cycle %0d: got %0d want %0d", cyc, grant_id, m.gid);
         end
         checks++;
         if (busy !== (m.mode != 2'd0)) begin
            errors++;
            $display("FAIL cmp_busy cycle %0d: got %b want %b", cyc, busy, (m.mode != 2'd0));
         end
         checks++;
         if (cfg_err !== m.err) begin
            errors++;
            $display("FAIL cmp_cfg_err cycle %0d: got %b want %b", cyc, cfg_err, m.err);
         end
         if (tick_en != 4'd0)
            $display("tick cycle %0d tick_en=%b grant_id=%0d", cyc, tick_en, grant_id);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed checks
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic next_cycle();
      @(negedge clock_in);
   endtask

   // Count negedges until a tick is visible; an expired bound shows up as a
   // gap mismatch.
   task automatic wait_tick(input string name, input int exp_gap, input logic [3:0] exp_tick);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clock_in);
         n++;
         if (tick_en != 4'd0) seen = 1'b1;
      end
      check({name, "_gap"}, n, exp_gap);
      check({name, "_val"}, int'(tick_en), int'(exp_tick));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      next_cycle();
      start = 1'b0;
   endtask

   // Called at the negedge where cnt==1 (the tick cycle): stops at cnt==2 and
   // measures how long DRAIN lasts after the stop edge.
   task automatic stop_and_drain(input string name);
      int n      = 0;
      int dticks = 0;
      next_cycle();
      stop = 1'b1;
      next_cycle();
      stop = 1'b0;
      check({name, "_busy_in_drain"}, int'(busy), 1);
      while (busy && n < 20) begin
         next_cycle();
         n++;
         if (tick_en != 4'd0) dticks++;
      end
      check({name, "_len"}, n, 3);
      check({name, "_ticks"}, dticks, 0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;
      check("rst_tick_en", int'(tick_en), 0);
      check("rst_grant_id", int'(grant_id), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cfg_err", int'(cfg_err), 0);

      // All stages requesting, div=6: strict rotation, one tick per 6 cycles
      req = 4'b1111;
      pulse_start();
      check("run_busy", int'(busy), 1);
      wait_tick("rr_t0", 1, 4'b0001);
      wait_tick("rr_t1", 6, 4'b0010);
      wait_tick("rr_t2", 6, 4'b0100);
      wait_tick("rr_t3", 6, 4'b1000);
      wait_tick("rr_t4", 6, 4'b0001);

      // Stages 0 and 2 requesting: alternation from pointer 1
      req = 4'b0101;
      wait_tick("alt_t0", 6, 4'b0100);
      wait_tick("alt_t1", 6, 4'b0001);
      wait_tick("alt_t2", 6, 4'b0100);
      check("alt_gid", int'(grant_id), 2);
      // Empty slot: no tick, pointer stays at 3 so stage 0 is next
      req = 4'b0000;
      repeat (7) next_cycle();
      req = 4'b0101;
      wait_tick("skip_t", 5, 4'b0001);
      check("skip_gid", int'(grant_id), 0);

      // Stop at cnt==2 -> DRAIN for three more edges
      stop_and_drain("drain1");

      // Rejected divisor write in IDLE
      cfg_we  = 1'b1;
      cfg_div = 28'd1;
      next_cycle();
      cfg_we = 1'b0;
      check("rej_err_pulse", int'(cfg_err), 1);
      next_cycle();
      check("rej_err_clear", int'(cfg_err), 0);

      // Divisor still 6; pointer continues at 1
      req = 4'b1111;
      pulse_start();
      wait_tick("div6_t0", 1, 4'b0010);
      wait_tick("div6_t1", 6, 4'b0100);
      stop_and_drain("drain2");

      // start and stop together in IDLE: stays IDLE
      start = 1'b1;
      stop  = 1'b1;
      next_cycle();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_idle0", int'(busy), 0);
      next_cycle();
      check("ss_idle1", int'(busy), 0);

      // Accepted divisor 3
      cfg_we  = 1'b1;
      cfg_div = 28'd3;
      next_cycle();
      cfg_we = 1'b0;
      check("acc_err", int'(cfg_err), 0);
      pulse_start();
      wait_tick("div3_t0", 1, 4'b1000);
      wait_tick("div3_t1", 3, 4'b0001);
      // Divisor write while running is refused
      cfg_we  = 1'b1;
      cfg_div = 28'd5;
      next_cycle();
      cfg_we = 1'b0;
      check("run_cfg_err", int'(cfg_err), 1);
      wait_tick("div3_t2", 2, 4'b0010);
      wait_tick("div3_t3", 3, 4'b0100);

      // Reset back to the default divisor, then reset mid-RUN at cnt==3
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check("rst2_busy", int'(busy), 0);
      pulse_start();
      wait_tick("mr_t0", 1, 4'b0001);
      wait_tick("mr_t1", 6, 4'b0010);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      check("mr_tick_en", int'(tick_en), 0);
      check("mr_grant_id", int'(grant_id), 0);
      check("mr_busy", int'(busy), 0);
      check("mr_cfg_err", int'(cfg_err), 0);
      rst = 1'b0;
      pulse_start();
      wait_tick("mr_restart0", 1, 4'b0001);
      wait_tick("mr_restart1", 6, 4'b0010);

      repeat (3) next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cnn_tick_scheduler.md
CNN_TICK_SCHEDULER -- requirements
Module: cnn_tick_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesting CNN stages (fixed at 4 in this revision).
REQ-002 SHALL have parameter CNT_W, default 28, divider counter width.
REQ-003 SHALL have parameter DIV_DEFAULT, default 6, divisor loaded at reset.
REQ-004 SHALL have port clock_in  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_we  input  1  divisor write strobe.
REQ-007 SHALL have port cfg_div  input  CNT_W  divisor value written on cfg_we.
REQ-008 SHALL have port start  input  1  start-scheduling pulse.
REQ-009 SHALL have port stop  input  1  stop-scheduling pulse.
REQ-010 SHALL have port req  input  N_REQ  per-stage tick request, level-sensitive.
REQ-011 SHALL have port tick_en  output  N_REQ  one-hot, one-cycle enable strobe to the granted stage.
REQ-012 SHALL have port grant_id  output  2  index of the most recent grant.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.
REQ-014 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected configuration write.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN; all outputs registered except busy (decoded from state).
REQ-016 SHALL hold divisor register div; cfg_we in IDLE with cfg_div>=2 loads div on that edge.
REQ-017 SHALL reject cfg_we when cfg_div<2 or state!=IDLE: div unchanged, cfg_err=1 for the following cycle only.
REQ-018 SHALL, in IDLE on an edge with start=1 and stop=0, move to RUN with period counter cnt=0.
REQ-019 SHALL, in RUN/DRAIN, increment cnt each edge, wrapping to 0 at edge where cnt==div-1.
REQ-020 SHALL, at an edge in RUN with cnt==0 and req!=0, grant the first set req bit searching from pointer ptr upward with wrap (ptr, ptr+1, ..., 3, 0, ...).
REQ-021 SHALL, on a grant to index g, set tick_en to one-hot g and grant_id=g for exactly one cycle, and set ptr=(g+1) mod 4.
REQ-022 SHALL drive tick_en=0 in every cycle not covered by REQ-021; at most one tick per div-cycle period.
REQ-023 SHALL, when cnt==0 in RUN and req==0, issue no tick and leave ptr and grant_id unchanged; the period slot is skipped.
REQ-024 SHALL, on stop=1 in RUN, move to DRAIN on that edge; a grant due on that same edge (cnt==0) is still issued.
REQ-025 SHALL issue no grants in DRAIN; at the edge where cnt==div-1 move to IDLE with cnt=0.
REQ-026 SHALL give stop priority over start on the same edge; start in RUN/DRAIN and stop in IDLE are ignored.
REQ-027 SHALL ignore req changes mid-period; only the value sampled at cnt==0 matters.

Reset
REQ-028 SHALL on rst=1 set state=IDLE, cnt=0, div=DIV_DEFAULT, ptr=0, tick_en=0, grant_id=0, cfg_err=0, busy=0, overriding all other inputs that edge, including mid-RUN/DRAIN.
REQ-029 SHALL leave div/ptr unchanged by start/stop; only rst and valid cfg_we alter div.

Verification
REQ-030 SHALL test: reset, start, req=4'b1111, div=6 -> tick_en 0001,0010,0100,1000,0001 every 6 cycles, first tick one cycle after RUN entry.
REQ-031 SHALL test: req=4'b0101 steady -> grants alternate index 0,2,0,2; req=0 for one period -> no tick, next grant continues from ptr.
REQ-032 SHALL test: cfg_we cfg_div=1 in IDLE -> cfg_err pulse, div stays 6; cfg_div=3 -> ticks every 3 cycles; cfg_we in RUN -> cfg_err, period unchanged.
REQ-033 SHALL test: stop at cnt==2, div=6 -> DRAIN, no tick, busy falls 3 cycles later (after cnt==5 edge); start+stop together in IDLE -> stays IDLE.
REQ-034 SHALL test: rst asserted mid-RUN at cnt==3 -> next cycle all outputs zero, div=6, ptr=0; restart grants index 0 first.
